// File: rtl/wb_stage.sv
// Write-back stage: latches the MEM->WB bus and commits register-file writes.
// It also owns HI/LO and the CP0 registers and raises cancel on an exception or eret.
module wb_stage #(
  parameter logic [31:0] EXC_ENTRY  = 32'hBFC00380,
  parameter logic [31:0] STATUS_RST = 32'h00400000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         MEM_over,
  input  logic [160:0] MEM_WB_bus,
  output logic         WB_valid,
  output logic [3:0]   rf_wen,
  output logic [4:0]   rf_wdest,
  output logic [31:0]  rf_wdata,
  output logic         WB_hi_write,
  output logic         WB_lo_write,
  output logic [31:0]  WB_hi_data,
  output logic [31:0]  WB_lo_data,
  output logic [31:0]  HI_data,
  output logic [31:0]  LO_data,
  output logic [31:0]  cp0r_status,
  output logic [31:0]  cp0r_cause,
  output logic [31:0]  cp0r_epc,
  output logic [31:0]  cp0r_badvaddr,
  output logic         cancel,
  output logic [31:0]  redirect_pc,
  output logic [31:0]  WB_pc
);

  localparam logic [7:0] ADDR_BADVADDR = {5'd8, 3'd0};
  localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

  logic [159:0] r_bus;
  logic         r_valid;
  logic         r_in_ds;
  logic [31:0]  r_hi, r_lo;
  logic [31:0]  r_status, r_cause, r_epc, r_badvaddr;

  logic w_unused;
  assign w_unused = MEM_WB_bus[160];

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
    end else begin
      r_valid <= MEM_over;
      if (MEM_over) r_bus <= MEM_WB_bus[159:0];
    end
  end

  logic [3:0]  w_wbytes;
  logic [31:0] w_pc, w_exe_result, w_lo_result, w_mem_result;
  logic        w_eret, w_ri, w_ades, w_adel, w_ov, w_brk, w_sys;
  logic [7:0]  w_cp0_addr;
  logic        w_mfc0, w_mtc0, w_mflo, w_mfhi, w_lo_wr, w_hi_wr;
  logic [4:0]  w_wdest;
  logic        w_wen, w_jbr;

  assign w_wbytes     = r_bus[3:0];
  assign w_pc         = r_bus[35:4];
  assign w_exe_result = r_bus[67:36];
  assign w_eret       = r_bus[68];
  assign w_ri         = r_bus[69];
  assign w_ades       = r_bus[70];
  assign w_adel       = r_bus[71];
  assign w_ov         = r_bus[72];
  assign w_brk        = r_bus[73];
  assign w_sys        = r_bus[74];
  assign w_cp0_addr   = r_bus[82:75];
  assign w_mfc0       = r_bus[83];
  assign w_mtc0       = r_bus[84];
  assign w_mflo       = r_bus[85];
  assign w_mfhi       = r_bus[86];
  assign w_lo_wr      = r_bus[87];
  assign w_hi_wr      = r_bus[88];
  assign w_lo_result  = r_bus[120:89];
  assign w_mem_result = r_bus[152:121];
  assign w_wdest      = r_bus[157:153];
  assign w_wen        = r_bus[158];
  assign w_jbr        = r_bus[159];

  logic       w_exc, w_commit;
  logic [4:0] w_exc_code;

  assign w_exc    = r_valid & (w_ri | w_sys | w_brk | w_ov | w_adel | w_ades);
  assign w_commit = r_valid & ~w_exc;

  always_comb begin
    w_exc_code = 5'd0;
    if (w_ri)        w_exc_code = 5'd10;
    else if (w_sys)  w_exc_code = 5'd8;
    else if (w_brk)  w_exc_code = 5'd9;
    else if (w_ov)   w_exc_code = 5'd12;
    else if (w_adel) w_exc_code = 5'd4;
    else if (w_ades) w_exc_code = 5'd5;
  end

  assign cancel      = r_valid & (w_exc | w_eret);
  assign redirect_pc = w_exc ? EXC_ENTRY : r_epc;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)        r_in_ds <= 1'b0;
    else if (cancel)   r_in_ds <= 1'b0;
    else if (r_valid)  r_in_ds <= w_jbr;
  end

  assign WB_hi_write = w_commit & w_hi_wr;
  assign WB_lo_write = w_commit & w_lo_wr;
  assign WB_hi_data  = w_mem_result;
  assign WB_lo_data  = w_lo_result;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (WB_hi_write) r_hi <= w_mem_result;
      if (WB_lo_write) r_lo <= w_lo_result;
    end
  end

  // Exception update takes precedence over any mtc0/eret in the same cycle.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_status   <= STATUS_RST;
      r_cause    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else if (w_exc) begin
      r_status[1]   <= 1'b1;
      r_cause[31]   <= r_in_ds;
      r_cause[6:2]  <= w_exc_code;
      r_epc         <= r_in_ds ? (w_pc - 32'd4) : w_pc;
      if (w_adel | w_ades) r_badvaddr <= w_exe_result;
    end else if (r_valid) begin
      if (w_mtc0) begin
        case (w_cp0_addr)
          ADDR_STATUS: begin
            r_status[15:8] <= w_mem_result[15:8];
            r_status[1:0]  <= w_mem_result[1:0];
          end
          ADDR_CAUSE:  r_cause[9:8] <= w_mem_result[9:8];
          ADDR_EPC:    r_epc        <= w_mem_result;
          default: ;
        endcase
      end
      if (w_eret) r_status[1] <= 1'b0;
    end
  end

  logic [31:0] w_cp0_rdata, w_mem_aligned;

  always_comb begin
    w_cp0_rdata = '0;
    case (w_cp0_addr)
      ADDR_STATUS:   w_cp0_rdata = r_status;
      ADDR_CAUSE:    w_cp0_rdata = r_cause;
      ADDR_EPC:      w_cp0_rdata = r_epc;
      ADDR_BADVADDR: w_cp0_rdata = r_badvaddr;
      default:       w_cp0_rdata = '0;
    endcase
  end

  // Partial-word lwl/lwr results are shifted into the lanes named by rf_wbytes.
  always_comb begin
    w_mem_aligned = w_mem_result;
    case (w_wbytes)
      4'b1000: w_mem_aligned = {w_mem_result[7:0], 24'b0};
      4'b1100: w_mem_aligned = {w_mem_result[15:0], 16'b0};
      4'b1110: w_mem_aligned = {w_mem_result[23:0], 8'b0};
      4'b0111: w_mem_aligned = {8'b0, w_mem_result[31:8]};
      4'b0011: w_mem_aligned = {16'b0, w_mem_result[31:16]};
      4'b0001: w_mem_aligned = {24'b0, w_mem_result[31:24]};
      default: w_mem_aligned = w_mem_result;
    endcase
  end

  always_comb begin
    rf_wdata = w_mem_aligned;
    if (w_mfhi)      rf_wdata = r_hi;
    else if (w_mflo) rf_wdata = r_lo;
    else if (w_mfc0) rf_wdata = w_cp0_rdata;
  end

  assign rf_wen   = {4{w_commit & w_wen}} & w_wbytes;
  assign rf_wdest = w_wdest;

  assign WB_valid      = r_valid;
  assign WB_pc         = w_pc;
  assign HI_data       = r_hi;
  assign LO_data       = r_lo;
  assign cp0r_status   = r_status;
  assign cp0r_cause    = r_cause;
  assign cp0r_epc      = r_epc;
  assign cp0r_badvaddr = r_badvaddr;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a behavioural model predicts each retirement,
// a negedge monitor compares outputs and the committed architectural state.
module tb_wb_stage;

  localparam logic [31:0] EXC_ENTRY  = 32'hBFC00380;
  localparam logic [31:0] STATUS_RST = 32'h00400000;

  typedef struct {
    logic [3:0]  bytes;
    logic [31:0] pc, exe, lo_res, mem;
    logic        eret, ri, ades, adel, ov, brk, sys;
    logic [7:0]  addr;
    logic        mfc0, mtc0, mflo, mfhi, lo_w, hi_w;
    logic [4:0]  dest;
    logic        wen, jbr;
  } instr_t;

  typedef struct {
    logic [3:0]  rf_wen;
    logic [4:0]  dest;
    logic [31:0] wdata, redirect, pc, hi_d, lo_d;
    logic        cancel, hi_w, lo_w;
    logic [31:0] status, cause, epc, bad, hi, lo;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         MEM_over = 1'b0;
  logic [160:0] MEM_WB_bus = '0;
  logic         WB_valid;
  logic [3:0]   rf_wen;
  logic [4:0]   rf_wdest;
  logic [31:0]  rf_wdata;
  logic         WB_hi_write, WB_lo_write;
  logic [31:0]  WB_hi_data, WB_lo_data, HI_data, LO_data;
  logic [31:0]  cp0r_status, cp0r_cause, cp0r_epc, cp0r_badvaddr;
  logic         cancel;
  logic [31:0]  redirect_pc, WB_pc;

  wb_stage dut (
    .clk(clk), .resetn(resetn), .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus),
    .WB_valid(WB_valid), .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata),
    .WB_hi_write(WB_hi_write), .WB_lo_write(WB_lo_write),
    .WB_hi_data(WB_hi_data), .WB_lo_data(WB_lo_data),
    .HI_data(HI_data), .LO_data(LO_data),
    .cp0r_status(cp0r_status), .cp0r_cause(cp0r_cause),
    .cp0r_epc(cp0r_epc), .cp0r_badvaddr(cp0r_badvaddr),
    .cancel(cancel), .redirect_pc(redirect_pc), .WB_pc(WB_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  exp_t q[$];
  exp_t post;
  bit   chk_post = 1'b0;

  logic [31:0] m_status, m_cause, m_epc, m_bad, m_hi, m_lo;
  bit          m_ds;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_status = STATUS_RST; m_cause = 0; m_epc = 0; m_bad = 0; m_hi = 0; m_lo = 0; m_ds = 0;
  endtask

  function automatic logic [31:0] cp0_read(input logic [7:0] a);
    if (a == 8'd96)  return m_status;
    if (a == 8'd104) return m_cause;
    if (a == 8'd112) return m_epc;
    if (a == 8'd64)  return m_bad;
    return 32'd0;
  endfunction

  // Lanes named by the byte mask: upper-anchored masks shift left, lower-anchored shift right.
  function automatic logic [31:0] align(input logic [3:0] b, input logic [31:0] m);
    case (b)
      4'b1000: return m << 24;
      4'b1100: return m << 16;
      4'b1110: return m << 8;
      4'b0111: return m >> 8;
      4'b0011: return m >> 16;
      4'b0001: return m >> 24;
      default: return m;
    endcase
  endfunction

  task automatic model_step(input instr_t t, output exp_t e);
    bit exc;
    logic [4:0] code;
    exc = t.ri | t.sys | t.brk | t.ov | t.adel | t.ades;
    code = t.ri ? 5'd10 : t.sys ? 5'd8 : t.brk ? 5'd9 : t.ov ? 5'd12 : t.adel ? 5'd4 : 5'd5;
    e.cancel   = exc | t.eret;
    e.redirect = exc ? EXC_ENTRY : m_epc;
    e.rf_wen   = (t.wen && !exc) ? t.bytes : 4'd0;
    e.dest     = t.dest;
    e.pc       = t.pc;
    if (t.mfhi)      e.wdata = m_hi;
    else if (t.mflo) e.wdata = m_lo;
    else if (t.mfc0) e.wdata = cp0_read(t.addr);
    else             e.wdata = align(t.bytes, t.mem);
    e.hi_w = t.hi_w & !exc;  e.hi_d = t.mem;
    e.lo_w = t.lo_w & !exc;  e.lo_d = t.lo_res;
    if (exc) begin
      m_status[1]  = 1'b1;
      m_cause[31]  = m_ds;
      m_cause[6:2] = code;
      m_epc        = m_ds ? t.pc - 32'd4 : t.pc;
      if (t.adel || t.ades) m_bad = t.exe;
    end else begin
      if (t.mtc0 && t.addr == 8'd96) begin
        m_status[15:8] = t.mem[15:8];
        m_status[1:0]  = t.mem[1:0];
      end
      if (t.mtc0 && t.addr == 8'd104) m_cause[9:8] = t.mem[9:8];
      if (t.mtc0 && t.addr == 8'd112) m_epc = t.mem;
      if (t.eret) m_status[1] = 1'b0;
      if (t.hi_w) m_hi = t.mem;
      if (t.lo_w) m_lo = t.lo_res;
    end
    m_ds = e.cancel ? 1'b0 : t.jbr;
    e.status = m_status; e.cause = m_cause; e.epc = m_epc; e.bad = m_bad;
    e.hi = m_hi; e.lo = m_lo;
  endtask

  function automatic logic [160:0] pack(input instr_t t);
    logic [160:0] b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b[3:0] = t.bytes;     b[35:4] = t.pc;      b[67:36] = t.exe;
    b[68] = t.eret;       b[69] = t.ri;        b[70] = t.ades;     b[71] = t.adel;
    b[72] = t.ov;         b[73] = t.brk;       b[74] = t.sys;      b[82:75] = t.addr;
    b[83] = t.mfc0;       b[84] = t.mtc0;      b[85] = t.mflo;     b[86] = t.mfhi;
    b[87] = t.lo_w;       b[88] = t.hi_w;      b[120:89] = t.lo_res;
    b[152:121] = t.mem;   b[157:153] = t.dest; b[158] = t.wen;     b[159] = t.jbr;
    return b;
  endfunction

  function automatic instr_t blank();
    instr_t t;
    t.bytes = 4'hF; t.pc = 32'hBFC00000; t.exe = 0; t.lo_res = 0; t.mem = 0;
    {t.eret, t.ri, t.ades, t.adel, t.ov, t.brk, t.sys} = '0;
    t.addr = 0; {t.mfc0, t.mtc0, t.mflo, t.mfhi, t.lo_w, t.hi_w} = '0;
    t.dest = 0; t.wen = 0; t.jbr = 0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    logic [3:0] masks [8] = '{4'hF, 4'h8, 4'hC, 4'hE, 4'h7, 4'h3, 4'h1, 4'h5};
    logic [7:0] addrs [5] = '{8'd96, 8'd104, 8'd112, 8'd64, 8'd0};
    int kind;
    logic [5:0] ex;
    t = blank();
    t.bytes = masks[$urandom_range(0, 7)];
    t.pc = $urandom & 32'hFFFF_FFFC;
    t.exe = $urandom; t.lo_res = $urandom; t.mem = $urandom;
    t.addr = addrs[$urandom_range(0, 4)];
    if (t.addr == 8'd0) t.addr = 8'($urandom);
    t.dest = 5'($urandom); t.wen = ($urandom_range(0, 3) != 0); t.jbr = 1'($urandom);
    kind = $urandom_range(0, 9);
    t.mfhi = (kind == 0); t.mflo = (kind == 1); t.mfc0 = (kind == 2);
    t.mtc0 = (kind == 3); t.eret = (kind == 4);
    t.hi_w = ($urandom_range(0, 2) == 0); t.lo_w = ($urandom_range(0, 2) == 0);
    ex = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
    {t.ri, t.sys, t.brk, t.ov, t.adel, t.ades} = ex;
    return t;
  endfunction

  // Called at posedge+1; returns at the following posedge+1 with t in WB.
  task automatic issue(input instr_t t);
    exp_t e;
    model_step(t, e);
    q.push_back(e);
    MEM_over = 1'b1;
    MEM_WB_bus = pack(t);
    @(posedge clk); #1;
    MEM_over = 1'b0;
    MEM_WB_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      chk_post = 1'b0;
    end else begin
      if (chk_post) begin
        check("post_status", cp0r_status, post.status);
        check("post_cause", cp0r_cause, post.cause);
        check("post_epc", cp0r_epc, post.epc);
        check("post_badvaddr", cp0r_badvaddr, post.bad);
        check("post_hi", HI_data, post.hi);
        check("post_lo", LO_data, post.lo);
        chk_post = 1'b0;
      end
      if (WB_valid) begin
        if (q.size() == 0) begin
          check("unexpected_retire", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rf_wen", {28'd0, rf_wen}, {28'd0, e.rf_wen});
          check("rf_wdest", {27'd0, rf_wdest}, {27'd0, e.dest});
          check("rf_wdata", rf_wdata, e.wdata);
          check("cancel", {31'd0, cancel}, {31'd0, e.cancel});
          if (e.cancel) check("redirect_pc", redirect_pc, e.redirect);
          check("WB_pc", WB_pc, e.pc);
          check("WB_hi_write", {31'd0, WB_hi_write}, {31'd0, e.hi_w});
          check("WB_lo_write", {31'd0, WB_lo_write}, {31'd0, e.lo_w});
          if (e.hi_w) check("WB_hi_data", WB_hi_data, e.hi_d);
          if (e.lo_w) check("WB_lo_data", WB_lo_data, e.lo_d);
          post = e;
          chk_post = 1'b1;
        end
      end else begin
        check("idle_cancel", {31'd0, cancel}, 32'd0);
      end
    end
  end

  initial begin
    instr_t t;
    model_reset();
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, WB_valid}, 32'd0);
    check("rst_cancel", {31'd0, cancel}, 32'd0);
    check("rst_status", cp0r_status, STATUS_RST);
    check("rst_cause", cp0r_cause, 32'd0);
    check("rst_epc", cp0r_epc, 32'd0);
    check("rst_hi", HI_data, 32'd0);
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;

    t = blank(); t.wen = 1; t.dest = 5; t.mem = 32'h12345678; t.bytes = 4'hF;
    issue(t);
    check("tp1_wen", {28'd0, rf_wen}, 32'hF);
    check("tp1_wdata", rf_wdata, 32'h12345678);
    check("tp1_cancel", {31'd0, cancel}, 32'd0);

    t = blank(); t.wen = 1; t.dest = 7; t.mem = 32'hAABBCCDD; t.bytes = 4'hC; t.jbr = 1;
    issue(t);
    check("tp2_wdata", rf_wdata, 32'hCCDD0000);
    check("tp2_wen", {28'd0, rf_wen}, 32'hC);

    t = blank(); t.sys = 1; t.pc = 32'hBFC00100; t.wen = 1; t.dest = 3;
    issue(t);
    check("tp3_cancel", {31'd0, cancel}, 32'd1);
    check("tp3_redirect", redirect_pc, 32'hBFC00380);
    check("tp3_wen", {28'd0, rf_wen}, 32'd0);
    idle(1);
    check("tp3_epc", cp0r_epc, 32'hBFC000FC);
    check("tp3_bd", {31'd0, cp0r_cause[31]}, 32'd1);
    check("tp3_code", {27'd0, cp0r_cause[6:2]}, 32'd8);
    check("tp3_exl", {31'd0, cp0r_status[1]}, 32'd1);

    t = blank(); t.adel = 1; t.exe = 32'h80000003; t.hi_w = 1; t.mem = 32'hDEAD0001;
    issue(t);
    idle(1);
    check("tp4_bad", cp0r_badvaddr, 32'h80000003);
    check("tp4_code", {27'd0, cp0r_cause[6:2]}, 32'd4);
    check("tp4_hi", HI_data, 32'd0);

    t = blank(); t.mtc0 = 1; t.addr = 8'd112; t.mem = 32'hBFC00200;
    issue(t);
    t = blank(); t.eret = 1;
    issue(t);
    check("tp5_cancel", {31'd0, cancel}, 32'd1);
    check("tp5_redirect", redirect_pc, 32'hBFC00200);
    idle(1);
    check("tp5_exl", {31'd0, cp0r_status[1]}, 32'd0);

    t = blank(); t.hi_w = 1; t.mem = 32'd7;
    issue(t);
    check("tp6_hiw", {31'd0, WB_hi_write}, 32'd1);
    check("tp6_hid", WB_hi_data, 32'd7);
    t = blank(); t.mfhi = 1; t.wen = 1; t.dest = 9;
    issue(t);
    check("tp6_mfhi", rf_wdata, 32'd7);

    for (int i = 0; i < 400; i++) begin
      issue(rand_instr());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    t = blank(); t.sys = 1; t.pc = 32'h00001000;
    issue(t);
    resetn = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, WB_valid}, 32'd0);
    check("mid_rst_cancel", {31'd0, cancel}, 32'd0);
    check("mid_rst_status", cp0r_status, STATUS_RST);
    check("mid_rst_epc", cp0r_epc, 32'd0);
    check("mid_rst_hi", HI_data, 32'd0);
    q.delete();
    model_reset();
    @(negedge clk); @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) issue(rand_instr());
    idle(3);
    check("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Registers the 161-bit MEM→WB bus and commits register-file writes with byte enables (lwl/lwr merging).
- Owns the HI/LO and CP0 (Status, Cause, EPC, BadVAddr) registers; detects exceptions and eret, and raises a one-cycle pipeline cancel with redirect PC.
- Feeds HI/LO/CP0 values back to the memory stage for mfhi/mflo/mfc0 forwarding.

Parameters:
EXC_ENTRY, 32'hBFC00380, exception redirect PC
STATUS_RST, 32'h00400000, Status reset value (BEV=1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-high reset
MEM_over  in  1  memory stage finished; bus valid this cycle
MEM_WB_bus  in  161  memory→WB bus; fields below
WB_valid  out  1  WB holds a valid instruction
rf_wen  out  4  register-file byte write enables
rf_wdest  out  5  destination register
rf_wdata  out  32  write data, lane-aligned
WB_hi_write / WB_lo_write  out  1 each  HI/LO write this cycle
WB_hi_data / WB_lo_data  out  32 each  data being written to HI/LO
HI_data / LO_data  out  32 each  current HI/LO
cp0r_status / cp0r_cause / cp0r_epc / cp0r_badvaddr  out  32 each  CP0 registers
cancel  out  1  flush upstream stages
redirect_pc  out  32  EXC_ENTRY on exception, EPC on eret
WB_pc  out  32  PC of the WB instruction (debug)

Behaviour:
- Bus fields, LSB first:
  - rf_wbytes[3:0], pc[35:4], exe_result[67:36]
  - eret[68], ri_ex[69], ades_ex[70], adel_ex[71], ov_ex[72], break[73], syscall[74]
  - cp0r_addr[82:75], mfc0[83], mtc0[84], mflo[85], mfhi[86], lo_write[87], hi_write[88]
  - lo_result[120:89], mem_result[152:121], rf_wdest[157:153], wen[158], inst_jbr[159]
  - bit 160 reserved and ignored.
- Pipeline register:
  - Bus latched on the clk edge when MEM_over=1. WB_valid<=MEM_over every cycle, so WB_valid=0 when MEM_over=0.
  - Single-cycle stage: WB_over == WB_valid.
  - Reset: WB_valid=0, bus register=0.
- Exception:
  - exc = WB_valid & (ri|syscall|break|ov|adel|ades).
  - ExcCode priority: RI=10 > Sys=8 > Bp=9 > Ov=12 > AdEL=4 > AdES=5.
  - cancel = WB_valid & (exc|eret), combinational, one cycle.
  - redirect_pc = exc ? EXC_ENTRY : EPC.
- Delay slot:
  - in_ds register <= inst_jbr on each valid retirement; cleared on cancel and reset.
  - On exception: Cause.BD(31)<=in_ds; EPC<=in_ds ? pc-4 : pc.
  - On exception: Status.EXL(1)<=1 and Cause.ExcCode[6:2]<=code.
  - adel/ades additionally set BadVAddr<=exe_result.
- eret: Status.EXL<=0; no other effect.
- mtc0 (WB_valid, no exc) uses data = mem_result:
  - addr {12,0}: Status[15:8] and [1:0] written.
  - addr {13,0}: Cause[9:8] written.
  - addr {14,0}: EPC fully written.
  - BadVAddr is read-only.
  - If exc occurs in the same cycle, the exception update wins.
- CP0 reset values: Status=STATUS_RST; Cause=0, EPC=0, BadVAddr=0.
- HI/LO:
  - HI<=mem_result when hi_write & WB_valid & ~exc.
  - LO<=lo_result when lo_write & WB_valid & ~exc.
  - Both reset to 0.
  - WB_hi_write/WB_lo_write follow the same qualification, combinationally.
- Register-file write:
  - rf_wen = {4{WB_valid & wen & ~exc}} & rf_wbytes.
  - src priority: mfhi→HI_data, mflo→LO_data, mfc0→CP0 read (Status/Cause/EPC/BadVAddr by addr, else 0), otherwise mem_result.
  - Lane alignment for the mem_result source, by rf_wbytes:
    - 1000 → {m[7:0],24'b0}
    - 1100 → {m[15:0],16'b0}
    - 1110 → {m[23:0],8'b0}
    - 0111 → {8'b0,m[31:8]}
    - 0011 → {16'b0,m[31:16]}
    - 0001 → {24'b0,m[31:24]}
    - else m.
- Reset asserted mid-operation: all state clears immediately; cancel=0 while reset is held.

Test Plan:
- Reset then MEM_over=1 with wen=1, wdest=5, mem_result=32'h12345678, rf_wbytes=1111 → next cycle: rf_wen=1111, rf_wdest=5, rf_wdata=12345678, cancel=0.
- Bus with rf_wbytes=1100, mem_result=32'hAABBCCDD → rf_wdata=32'hCCDD0000, rf_wen=1100.
- syscall at pc=32'hBFC00100, previous retirement had inst_jbr=1 → cancel=1, redirect_pc=BFC00380; then EPC=BFC000FC, Cause.BD=1, ExcCode=8, EXL=1; rf_wen=0.
- adel with exe_result=32'h80000003 and hi_write=1 → BadVAddr=80000003, ExcCode=4, HI unchanged.
- mtc0 to EPC with data 32'hBFC00200, then eret → cancel=1, redirect_pc=BFC00200, EXL=0.
- hi_write=1 with mem_result=7, then mfhi → WB_hi_write pulse, WB_hi_data=7; next instruction rf_wdata=7.
